key_conditioner: RTL

Front-end input stage for the board-level storage task: takes the raw active-low push-button keys (record, transfer, and any further keys), synchronises them to `clk`, debounces them, and emits clean single-cycle press pulses. The storage block consumes these pulses directly as its record/transfer commands. Each key is handled by an independent, identical channel.

---
 rtl/key_cond_pkg.sv | 6 +
 rtl/key_channel.sv | 65 ++++++
 rtl/key_conditioner.sv | 32 +++
 3 files changed

// File: rtl/key_cond_pkg.sv
// key_cond_pkg: debounce state encoding and key index constants for the key conditioner
package key_cond_pkg;
    typedef enum logic [1:0] {RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT} key_state_e;
    localparam int KEY_RECORD   = 0;
    localparam int KEY_TRANSFER = 1;
endpackage

// File: rtl/key_channel.sv
// key_channel: one key's 2-flop synchroniser, debounce FSM/counter and pulse registers
// (KEY_COND_RELEASE_EN adds the release_pulse output)
module key_channel
    import key_cond_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n,
    output logic level,
    output logic press
`ifdef KEY_COND_RELEASE_EN
    ,
    output logic release_pulse
`endif
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
    logic s1_q, s2_q, press_q, press_d;
    logic [CW-1:0] cnt_q, cnt_d;
    key_state_e state_q, state_d;
    logic pressing, hold, done;
`ifdef KEY_COND_RELEASE_EN
    logic release_q, release_d;
    assign release_pulse = release_q;
`endif
    assign level = (state_q == PRESSED) || (state_q == RELEASE_WAIT);
    assign press = press_q;
    // The idle state counts the first differing sample too, so DEBOUNCE_CYCLES=1 accepts at once.
    always_comb begin
        pressing = (state_q == RELEASED) || (state_q == PRESS_WAIT);
        hold     = pressing ? s2_q : ~s2_q;
        done     = hold && (cnt_q == LAST);
        state_d  = done ? (pressing ? PRESSED : RELEASED)
                 : hold ? (pressing ? PRESS_WAIT : RELEASE_WAIT)
                 : (pressing ? RELEASED : PRESSED);
        cnt_d    = (hold && !done) ? cnt_q + 1'b1 : '0;
        press_d  = done && pressing;
`ifdef KEY_COND_RELEASE_EN
        release_d = done && !pressing;
`endif
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            state_q <= RELEASED;
            cnt_q   <= '0;
            press_q <= 1'b0;
`ifdef KEY_COND_RELEASE_EN
            release_q <= 1'b0;
`endif
        end else begin
            s1_q    <= ~key_n;
            s2_q    <= s1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            press_q <= press_d;
`ifdef KEY_COND_RELEASE_EN
            release_q <= release_d;
`endif
        end
    end
endmodule

// File: rtl/key_conditioner.sv
// key_conditioner: N_KEYS independent debounced key channels producing press pulses
// (KEY_COND_RELEASE_EN adds per-key release_pulse outputs)
module key_conditioner
    import key_cond_pkg::*;
#(
    parameter int N_KEYS          = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_KEYS-1:0] key_n,
    output logic [N_KEYS-1:0] level,
    output logic [N_KEYS-1:0] press
`ifdef KEY_COND_RELEASE_EN
    ,
    output logic [N_KEYS-1:0] release_pulse
`endif
);
    for (genvar k = 0; k < N_KEYS; k++) begin : g_ch
        key_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_ch (
            .clk           (clk),
            .rst           (rst),
            .key_n         (key_n[k]),
            .level         (level[k]),
            .press         (press[k])
`ifdef KEY_COND_RELEASE_EN
            ,
            .release_pulse (release_pulse[k])
`endif
        );
    end
endmodule
